// File: rtl/fetch_definitions.sv
// Shared encodings and default sizing for the instruction fetch request engine.
package fetch_definitions;

  localparam int FETCH_PC_WIDTH        = 32;
  localparam int FETCH_INSTR_WIDTH     = 32;
  localparam int FETCH_MAX_OUTSTANDING = 2;
  localparam int FETCH_PC_STEP         = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_credit_counter.sv
// Up/down saturating credit counter tracking accepted-but-unanswered fetch requests.
module fetch_credit_counter #(
  parameter int  MAX_COUNT = 2,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          zero,
  output logic          next_zero
);

  logic [CW-1:0] count_next;

  // Saturates at both ends; a simultaneous inc and dec leaves the count unchanged.
  always_comb begin
    count_next = count;
    unique case ({inc, dec})
      2'b10: if (count != CW'(MAX_COUNT)) count_next = count + CW'(1);
      2'b01: if (count != '0) count_next = count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else      count <= count_next;
  end

  assign full      = (count == CW'(MAX_COUNT));
  assign zero      = (count == '0);
  assign next_zero = (count_next == '0);

endmodule

// File: rtl/fetch_request_ctrl.sv
// Producer-side fetch engine for the wavefront instruction buffer queue.
// Optional sticky rsp_err output is built when FETCH_RSP_CHECK_EN is defined.
module fetch_request_ctrl
  import fetch_definitions::*;
#(
  parameter int  PC_WIDTH        = FETCH_PC_WIDTH,
  parameter int  INSTR_WIDTH     = FETCH_INSTR_WIDTH,
  parameter int  MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter int  PC_STEP         = FETCH_PC_STEP,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   halt,
  input  logic                   stop_fetch,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  output logic                   imem_req_tag,
  input  logic                   imem_rsp_valid,
  input  logic                   imem_rsp_tag,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   q_vtail_incr,
  output logic                   q_wr,
  output logic [INSTR_WIDTH-1:0] buff_wr_data,
  output logic                   q_reset,
  output logic                   busy,
  output logic [CNT_W-1:0]       outstanding
`ifdef FETCH_RSP_CHECK_EN
  ,
  output logic                   rsp_err
`endif
);

  fetch_state_e        state, state_next;
  logic [PC_WIDTH-1:0] pc;
  logic                epoch;
  logic                fire, start_take, redirect_take, rsp_write;
  logic                cnt_full, cnt_zero, cnt_next_zero;

  fetch_credit_counter #(.MAX_COUNT(MAX_OUTSTANDING)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .inc       (fire),
    .dec       (imem_rsp_valid),
    .count     (outstanding),
    .full      (cnt_full),
    .zero      (cnt_zero),
    .next_zero (cnt_next_zero)
  );

  assign start_take    = (state == FETCH_IDLE) & start;
  assign redirect_take = (state == FETCH_RUN) & redirect & ~halt;

  assign imem_req_valid = (state == FETCH_RUN) & ~stop_fetch & ~cnt_full
                        & ~redirect & ~halt & ~q_reset;
  assign fire           = imem_req_valid & imem_req_ready;
  assign q_vtail_incr   = fire;
  assign imem_req_addr  = pc;
  assign imem_req_tag   = epoch;
  assign busy           = (state != FETCH_IDLE);

  // Responses in IDLE or with nothing outstanding cannot belong to the live stream.
  assign rsp_write = imem_rsp_valid & (imem_rsp_tag == epoch) & ~redirect_take
                   & (state != FETCH_IDLE) & ~cnt_zero;

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH_IDLE:  if (start) state_next = FETCH_RUN;
      FETCH_RUN:   if (halt) state_next = FETCH_DRAIN;
      FETCH_DRAIN: if (cnt_next_zero) state_next = FETCH_IDLE;
      default:     state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH_IDLE;
      pc           <= '0;
      epoch        <= 1'b0;
      q_reset      <= 1'b0;
      q_wr         <= 1'b0;
      buff_wr_data <= '0;
    end else begin
      state   <= state_next;
      q_reset <= start_take | redirect_take;
      q_wr    <= rsp_write;
      if (rsp_write) buff_wr_data <= imem_rsp_data;
      if (start_take) begin
        pc <= start_pc;
      end else if (redirect_take) begin
        pc    <= redirect_pc;
        epoch <= ~epoch;
      end else if (fire) begin
        pc <= pc + PC_WIDTH'(PC_STEP);
      end
    end
  end

`ifdef FETCH_RSP_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsp_err <= 1'b0;
    else if (imem_rsp_valid & (cnt_zero | ((state == FETCH_IDLE) & (imem_rsp_tag == epoch))))
      rsp_err <= 1'b1;
  end
`endif

endmodule
